// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if: ID-stage hazard inputs and pipeline control outputs of the hazard controller
interface hazard_ctrl_if #(parameter int CNT_W = 16);
    logic             id_valid;
    logic [4:0]       id_rs1;
    logic [4:0]       id_rs2;
    logic             id_uses_rs1;
    logic             id_uses_rs2;
    logic [4:0]       id_rd;
    logic             id_reg_write;
    logic             id_mem_read;
    logic             branch_taken;
    logic             pc_write;
    logic             if_id_write;
    logic             id_ex_bubble;
    logic             if_id_flush;
    logic             id_ex_flush;
    logic             ex_mem_flush;
    logic [1:0]       fwd_A;
    logic [1:0]       fwd_B;
    logic [CNT_W-1:0] stall_count;
    logic [CNT_W-1:0] flush_count;
    modport master (
        output id_valid, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, id_rd, id_reg_write, id_mem_read, branch_taken,
        input  pc_write, if_id_write, id_ex_bubble, if_id_flush, id_ex_flush, ex_mem_flush, fwd_A, fwd_B,
               stall_count, flush_count
    );
    modport slave (
        input  id_valid, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, id_rd, id_reg_write, id_mem_read, branch_taken,
        output pc_write, if_id_write, id_ex_bubble, if_id_flush, id_ex_flush, ex_mem_flush, fwd_A, fwd_B,
               stall_count, flush_count
    );
endinterface

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: forwarding selects, load-use stall and taken-branch flush control for the 5-stage core
module hazard_ctrl #(
    parameter int CNT_W = 16
) (
    input logic         clock,
    input logic         reset,
    hazard_ctrl_if.slave bus
);
    typedef enum logic {RUN, STALL} state_t;
    state_t           state;
    logic [4:0]       ex_rd, mem_rd;
    logic             ex_rw, ex_mr, mem_rw;
    logic [1:0]       fwd_a, fwd_b;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;
    logic             ex_m1, ex_m2, mem_m1, mem_m2, load_use, stall, flush, kill;
    always_comb begin
        ex_m1    = ex_rw && ex_rd != 5'd0 && ex_rd == bus.id_rs1;
        ex_m2    = ex_rw && ex_rd != 5'd0 && ex_rd == bus.id_rs2;
        mem_m1   = mem_rw && mem_rd != 5'd0 && mem_rd == bus.id_rs1;
        mem_m2   = mem_rw && mem_rd != 5'd0 && mem_rd == bus.id_rs2;
        load_use = state == RUN && ex_mr && bus.id_valid &&
                   ((ex_m1 && bus.id_uses_rs1) || (ex_m2 && bus.id_uses_rs2));
        flush    = bus.branch_taken;
        stall    = load_use && !flush;
        kill     = stall || flush;
    end
    assign bus.pc_write     = !stall;
    assign bus.if_id_write  = !stall;
    assign bus.id_ex_bubble = stall;
    assign bus.if_id_flush  = flush;
    assign bus.id_ex_flush  = flush;
    assign bus.ex_mem_flush = flush;
    assign bus.fwd_A        = fwd_a;
    assign bus.fwd_B        = fwd_b;
    assign bus.stall_count  = stall_cnt;
    assign bus.flush_count  = flush_cnt;
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= RUN;
            ex_rd     <= '0;
            ex_rw     <= 1'b0;
            ex_mr     <= 1'b0;
            mem_rd    <= '0;
            mem_rw    <= 1'b0;
            fwd_a     <= 2'b00;
            fwd_b     <= 2'b00;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            state  <= stall ? STALL : RUN;
            mem_rd <= flush ? 5'd0 : ex_rd;
            mem_rw <= !flush && ex_rw;
            ex_rd  <= kill ? 5'd0 : bus.id_rd;
            ex_rw  <= !kill && bus.id_valid && bus.id_reg_write;
            ex_mr  <= !kill && bus.id_valid && bus.id_mem_read;
            // EX/MEM result is the younger one, so it wins over MEM/WB
            fwd_a  <= (kill || !bus.id_uses_rs1) ? 2'b00 : ex_m1 ? 2'b10 : mem_m1 ? 2'b01 : 2'b00;
            fwd_b  <= (kill || !bus.id_uses_rs2) ? 2'b00 : ex_m2 ? 2'b10 : mem_m2 ? 2'b01 : 2'b00;
            if (stall && !(&stall_cnt))
                stall_cnt <= stall_cnt + 1'b1;
            if (flush && !(&flush_cnt))
                flush_cnt <= flush_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed and randomized checks of hazard_ctrl against an instruction-level model
module tb_hazard_ctrl;
    localparam int CW  = 4;
    localparam int MAX = (1 << CW) - 1;
    logic clock, reset;
    int   n_cmp, n_bad;
    hazard_ctrl_if #(.CNT_W(CW)) bus();
    hazard_ctrl #(.CNT_W(CW)) dut (.clock(clock), .reset(reset), .bus(bus));
    initial clock = 1'b0;
    always #5 clock = ~clock;
    typedef struct packed {logic w; logic ld; logic [4:0] rd;} ins_t;
    ins_t m_ex, m_mem;
    bit   m_held;
    int   m_fa, m_fb, m_sc, m_fc;
    function automatic bit writes(ins_t i, logic [4:0] rs);
        return i.w && i.rd != 5'd0 && i.rd == rs;
    endfunction
    function automatic int m_src(logic [4:0] rs, logic used);
        if (!used) return 0;
        if (writes(m_ex, rs)) return 2;
        if (writes(m_mem, rs)) return 1;
        return 0;
    endfunction
    function automatic bit m_stall();
        return !m_held && !bus.branch_taken && bus.id_valid && m_ex.ld &&
               ((bus.id_uses_rs1 && writes(m_ex, bus.id_rs1)) || (bus.id_uses_rs2 && writes(m_ex, bus.id_rs2)));
    endfunction
    always @(posedge clock or posedge reset) begin
        if (reset) begin
            m_ex <= '0; m_mem <= '0; m_held <= 1'b0;
            m_fa <= 0; m_fb <= 0; m_sc <= 0; m_fc <= 0;
        end else begin
            m_mem  <= bus.branch_taken ? ins_t'(0) : m_ex;
            m_ex   <= (m_stall() || bus.branch_taken) ? ins_t'(0) :
                      {bus.id_valid && bus.id_reg_write, bus.id_valid && bus.id_mem_read, bus.id_rd};
            m_fa   <= (m_stall() || bus.branch_taken) ? 0 : m_src(bus.id_rs1, bus.id_uses_rs1);
            m_fb   <= (m_stall() || bus.branch_taken) ? 0 : m_src(bus.id_rs2, bus.id_uses_rs2);
            m_sc   <= (m_stall() && m_sc < MAX) ? m_sc + 1 : m_sc;
            m_fc   <= (bus.branch_taken && m_fc < MAX) ? m_fc + 1 : m_fc;
            m_held <= m_stall();
        end
    end
    task automatic chk(string name, int act, int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask
    always @(negedge clock) begin
        if (!reset) begin
            chk("pc_write", int'(bus.pc_write), int'(!m_stall()));
            chk("if_id_write", int'(bus.if_id_write), int'(!m_stall()));
            chk("id_ex_bubble", int'(bus.id_ex_bubble), int'(m_stall()));
            chk("if_id_flush", int'(bus.if_id_flush), int'(bus.branch_taken));
            chk("id_ex_flush", int'(bus.id_ex_flush), int'(bus.branch_taken));
            chk("ex_mem_flush", int'(bus.ex_mem_flush), int'(bus.branch_taken));
            chk("fwd_A", int'(bus.fwd_A), m_fa);
            chk("fwd_B", int'(bus.fwd_B), m_fb);
            chk("stall_count", int'(bus.stall_count), m_sc);
            chk("flush_count", int'(bus.flush_count), m_fc);
        end
    end
    task automatic issue(logic v, logic [4:0] rs1, logic u1, logic [4:0] rs2, logic u2,
                         logic [4:0] rd, logic rw, logic mr, logic br);
        @(posedge clock);
        #1;
        bus.id_valid = v; bus.id_rs1 = rs1; bus.id_uses_rs1 = u1; bus.id_rs2 = rs2; bus.id_uses_rs2 = u2;
        bus.id_rd = rd; bus.id_reg_write = rw; bus.id_mem_read = mr; bus.branch_taken = br;
    endtask
    task automatic nop();
        issue(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask
    initial begin
        n_cmp = 0; n_bad = 0;
        bus.id_valid = 0; bus.id_rs1 = 0; bus.id_rs2 = 0; bus.id_uses_rs1 = 0; bus.id_uses_rs2 = 0;
        bus.id_rd = 0; bus.id_reg_write = 0; bus.id_mem_read = 0; bus.branch_taken = 0;
        reset = 1'b1;
        #12;
        chk("rst pc_write", int'(bus.pc_write), 1);
        chk("rst fwd_A", int'(bus.fwd_A), 0);
        chk("rst stall_count", int'(bus.stall_count), 0);
        chk("rst flush_count", int'(bus.flush_count), 0);
        reset = 1'b0;
        // ALU chain on x5
        issue(1, 0, 0, 0, 0, 5, 1, 0, 0);
        issue(1, 5, 1, 0, 0, 6, 1, 0, 0);
        issue(1, 0, 0, 5, 1, 7, 1, 0, 0);
        @(negedge clock) chk("chain fwd_A", int'(bus.fwd_A), 2);
        nop();
        @(negedge clock) chk("chain fwd_B", int'(bus.fwd_B), 1);
        // load-use on x3
        issue(1, 0, 0, 0, 0, 3, 1, 1, 0);
        issue(1, 0, 0, 3, 1, 8, 1, 0, 0);
        @(negedge clock) begin
            chk("lu pc_write", int'(bus.pc_write), 0);
            chk("lu bubble", int'(bus.id_ex_bubble), 1);
        end
        issue(1, 0, 0, 3, 1, 8, 1, 0, 0);
        @(negedge clock) begin
            chk("lu resume pc_write", int'(bus.pc_write), 1);
            chk("lu stall_count", int'(bus.stall_count), 1);
        end
        nop();
        @(negedge clock) chk("lu fwd_B", int'(bus.fwd_B), 1);
        // x0 writer and immediate operand
        issue(1, 0, 0, 0, 0, 0, 1, 1, 0);
        issue(1, 0, 1, 0, 0, 9, 1, 0, 0);
        @(negedge clock) chk("x0 no stall", int'(bus.pc_write), 1);
        issue(1, 0, 0, 9, 0, 10, 1, 0, 0);
        @(negedge clock) chk("x0 fwd_A", int'(bus.fwd_A), 0);
        nop();
        @(negedge clock) chk("imm fwd_B", int'(bus.fwd_B), 0);
        // branch concurrent with load-use
        issue(1, 0, 0, 0, 0, 4, 1, 1, 0);
        issue(1, 4, 1, 0, 0, 11, 1, 0, 1);
        @(negedge clock) begin
            chk("br if_id_flush", int'(bus.if_id_flush), 1);
            chk("br id_ex_flush", int'(bus.id_ex_flush), 1);
            chk("br ex_mem_flush", int'(bus.ex_mem_flush), 1);
            chk("br pc_write", int'(bus.pc_write), 1);
            chk("br bubble", int'(bus.id_ex_bubble), 0);
        end
        nop();
        @(negedge clock) begin
            chk("br fwd_A", int'(bus.fwd_A), 0);
            chk("br flush_count", int'(bus.flush_count), 1);
            chk("br stall_count", int'(bus.stall_count), 1);
        end
        // saturate the stall counter
        repeat ((1 << CW) + 3) begin
            issue(1, 0, 0, 0, 0, 3, 1, 1, 0);
            issue(1, 3, 1, 0, 0, 12, 1, 0, 0);
            issue(1, 3, 1, 0, 0, 12, 1, 0, 0);
        end
        nop();
        @(negedge clock) chk("sat stall_count", int'(bus.stall_count), MAX);
        // asynchronous reset in the middle of a stall
        issue(1, 0, 0, 0, 0, 3, 1, 1, 0);
        issue(1, 0, 0, 3, 1, 13, 1, 0, 0);
        #2 reset = 1'b1;
        #1;
        chk("arst pc_write", int'(bus.pc_write), 1);
        chk("arst bubble", int'(bus.id_ex_bubble), 0);
        chk("arst stall_count", int'(bus.stall_count), 0);
        chk("arst fwd_B", int'(bus.fwd_B), 0);
        reset = 1'b0;
        // random traffic over a small register set to provoke frequent matches
        for (int i = 0; i < 3000; i++) begin
            @(posedge clock);
            #1;
            if (!m_held) begin
                bus.id_valid     = ($urandom_range(7) != 0);
                bus.id_rs1       = 5'($urandom_range(3));
                bus.id_rs2       = 5'($urandom_range(3));
                bus.id_uses_rs1  = 1'($urandom);
                bus.id_uses_rs2  = 1'($urandom);
                bus.id_rd        = 5'($urandom_range(3));
                bus.id_reg_write = 1'($urandom);
                bus.id_mem_read  = 1'($urandom);
            end
            bus.branch_taken = ($urandom_range(9) == 0);
        end
        nop();
        @(negedge clock);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
